sprot_xfer_sched: RTL
=====================

// Module: sprot_xfer_sched
// PURPOSE
//  Shares one sprot protocol port among NUM_REQ requesters.
//  Round-robin arbitration picks a requester, then the block sequences start -> a -> b on the shared port.
//  It waits for the sprot xfer_end/prot_err response and returns a per-requester done/err pulse.
//  Per-requester fault controls allow deliberate protocol violations for checker testing.
// PARAMETERS
//  NUM_REQ   4   number of requesters, 2..8
//  TIMEOUT   8   max cycles in C_WAIT for xfer_end before a forced error completion
//  CNT_W     16  width of the saturating error counter
// PORTS
//  clk       in   1        clock
//  rst_n     in   1        reset, synchronous, active-low
//  req       in   NUM_REQ  level request; held until done[i]
//  fault_a   in   NUM_REQ  suppress a for requester i (sampled at grant)
//  fault_b   in   NUM_REQ  suppress b for requester i (sampled at grant)
//  gnt       out  NUM_REQ  one-hot owner, high from C_START through completion
//  done      out  NUM_REQ  1-cycle completion pulse to owner
//  err       out  NUM_REQ  qualifies done: 1 = prot_err or timeout
//  start     out  1        to sprot start
//  a         out  1        to sprot a
//  b         out  1        to sprot b
//  prot_err  in   1        from sprot
//  xfer_end  in   1        from sprot
//  err_cnt   out  CNT_W    saturating count of err completions
// BEHAVIOUR
//  Reset: all outputs 0; state C_IDLE; RR pointer selects req[0] first; timeout counter 0.
//  FSM (sprot_ctl_st_t):
//   C_IDLE  - if |req: latch winner and its fault bits; gnt<=winner; go C_START.
//             Otherwise stay.
//   C_START - start=1 for exactly 1 cycle; go C_A.
//   C_A     - a = ~fault_a_lat for 1 cycle; go C_B.
//   C_B     - b = ~fault_b_lat for 1 cycle; go C_WAIT.
//   C_WAIT  - start/a/b = 0; timeout counter increments each cycle.
//             If xfer_end=1: done[own]=1, err[own]=prot_err; go C_GAP.
//             Else if counter reaches TIMEOUT: done[own]=1, err[own]=1; go C_GAP.
//   C_GAP   - gnt=0 for 1 cycle so sprot returns to IDLE; go C_IDLE.
//  Latency, grant to done with immediate xfer_end: C_START..C_WAIT = 4 cycles minimum.
//   Back-to-back grants are separated by at least 1 C_GAP + 1 C_IDLE cycle.
//  xfer_end before C_WAIT: ignored; no early completion.
//  Round robin: search starts at (last_owner+1) mod NUM_REQ.
//   Pointer updates only on grant. A lone requester is re-granted every 6 cycles.
//  req[i] dropped while i owns the port: transfer still completes; done/err still pulsed.
//  req of a non-owner never changes the current transfer.
//  Simultaneous requests: exactly one gnt bit. No requester waits more than NUM_REQ-1 transfers.
//  err_cnt: +1 on each done with err=1; saturates at 2**CNT_W-1; no wrap.
//  rst_n low mid-transfer: next edge forces reset values.
//   No done is issued for the aborted transfer.
//  Outputs are registered; no combinational path from inputs to start/a/b/gnt.
// STRUCTURE
//  sprot_pkg gains sprot_ctl_st_t {C_IDLE,C_START,C_A,C_B,C_WAIT,C_GAP}.
//   It also holds SPROT_GAP_CYC=1.
//  Sub-module sprot_rr_arb (req, ptr -> one-hot grant, grant index).
//   It is purely combinational; the pointer register lives in this block.
//  Top module holds the FSM, latched fault bits, timeout counter and err_cnt.
// TESTING
//  1. req=4'b0001, sprot model returns xfer_end=1, prot_err=0 one cycle into C_WAIT
//     -> start,a,b single pulses on consecutive cycles; done[0]=1, err[0]=0; err_cnt=0.
//  2. req=4'b1111 held -> gnt sequence 0,1,2,3,0; each done pulse matches the owner; no grant overlap.
//  3. req=4'b0100, fault_a[2]=1, model returns prot_err=1
//     -> a stays 0 through C_A; done[2]=1 with err[2]=1; err_cnt=1.
//  4. req=4'b0010, model never asserts xfer_end
//     -> done[1]=1, err[1]=1 exactly TIMEOUT=8 cycles after entering C_WAIT.
//  5. rst_n=0 during C_A of a transfer -> next cycle all outputs 0.
//     After release, req[0] is granted first and no stale done appears.
//  6. CNT_W=2, 5 consecutive faulted transfers -> err_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/sprot_pkg.sv
// Shared types and constants for the sprot transfer scheduler.
// The controller FSM states and the post-transfer idle gap length are defined here.
package sprot_pkg;

    typedef enum logic [2:0] {
        C_IDLE,
        C_START,
        C_A,
        C_B,
        C_WAIT,
        C_GAP
    } sprot_ctl_st_t;

    // Cycles with gnt low after each completion so the sprot port drops back to IDLE.
    localparam int SPROT_GAP_CYC = 1;

endpackage

// File: rtl/sprot_rr_arb.sv
// Combinational round-robin picker: the first asserted req at or after ptr wins.
// The rotating pointer is owned by the caller, which advances it only on a grant.
module sprot_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IW-1:0]      gnt_idx,
    output logic               gnt_vld
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (!gnt_vld && req[cand]) begin
                gnt_vld      = 1'b1;
                gnt_idx      = cand;
                gnt_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprot_xfer_sched.sv
// Shares one sprot port among NUM_REQ requesters: round-robin grant, start/a/b sequencing,
// completion on xfer_end or timeout, per-requester fault injection and a saturating error count.
module sprot_xfer_sched
    import sprot_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] fault_a,
    input  logic [NUM_REQ-1:0] fault_b,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] err,
    output logic               start,
    output logic               a,
    output logic               b,
    input  logic               prot_err,
    input  logic               xfer_end,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    sprot_ctl_st_t      state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic               fault_a_lat_q, fault_a_lat_d;
    logic               fault_b_lat_q, fault_b_lat_d;
    logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic               start_q, start_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [NUM_REQ-1:0] arb_oh;
    logic [IW-1:0]      arb_idx;
    logic               arb_vld;
    logic               fin;
    logic               fin_err;

    sprot_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Outputs are next-state decoded so start/a/b/gnt come straight from flops.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        ptr_d         = ptr_q;
        fault_a_lat_d = fault_a_lat_q;
        fault_b_lat_d = fault_b_lat_q;
        tmo_cnt_d     = tmo_cnt_q;
        err_cnt_d     = err_cnt_q;
        done_d        = '0;
        err_d         = '0;
        start_d       = 1'b0;
        a_d           = 1'b0;
        b_d           = 1'b0;
        fin           = 1'b0;
        fin_err       = 1'b0;

        case (state_q)
            C_IDLE: begin
                if (arb_vld) begin
                    state_d       = C_START;
                    gnt_d         = arb_oh;
                    fault_a_lat_d = fault_a[arb_idx];
                    fault_b_lat_d = fault_b[arb_idx];
                    ptr_d         = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    start_d       = 1'b1;
                end
            end
            C_START: begin
                state_d = C_A;
                a_d     = ~fault_a_lat_q;
            end
            C_A: begin
                state_d = C_B;
                b_d     = ~fault_b_lat_q;
            end
            C_B: begin
                state_d   = C_WAIT;
                tmo_cnt_d = '0;
            end
            C_WAIT: begin
                if (xfer_end) begin
                    fin     = 1'b1;
                    fin_err = prot_err;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            C_GAP: begin
                // Gap length reuses the timeout counter, cleared on completion.
                if (tmo_cnt_q == TW'(SPROT_GAP_CYC - 1)) begin
                    state_d   = C_IDLE;
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = C_IDLE;
        endcase

        if (fin) begin
            state_d   = C_GAP;
            gnt_d     = '0;
            tmo_cnt_d = '0;
            done_d    = gnt_q;
            err_d     = {NUM_REQ{fin_err}} & gnt_q;
            if (fin_err && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= C_IDLE;
            gnt_q         <= '0;
            done_q        <= '0;
            err_q         <= '0;
            ptr_q         <= '0;
            fault_a_lat_q <= 1'b0;
            fault_b_lat_q <= 1'b0;
            tmo_cnt_q     <= '0;
            start_q       <= 1'b0;
            a_q           <= 1'b0;
            b_q           <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            err_q         <= err_d;
            ptr_q         <= ptr_d;
            fault_a_lat_q <= fault_a_lat_d;
            fault_b_lat_q <= fault_b_lat_d;
            tmo_cnt_q     <= tmo_cnt_d;
            start_q       <= start_d;
            a_q           <= a_d;
            b_q           <= b_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign start   = start_q;
    assign a       = a_q;
    assign b       = b_q;
    assign err_cnt = err_cnt_q;

endmodule
